// File: rtl/uart_pkg.sv
// Shared types for the UART transmit queue: byte width and launch-FSM state encoding.
package uart_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic [2:0] {
    SYNC      = 3'd0,
    IDLE      = 3'd1,
    LAUNCH    = 3'd2,
    WAIT_LOW  = 3'd3,
    WAIT_HIGH = 3'd4
  } tx_state_t;

endpackage

// File: rtl/tx_fifo_ram.sv
// Queue storage: synchronous write, asynchronous read (LUTRAM style), no reset on contents.
module tx_fifo_ram
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [DEPTH_LOG2-1:0]  wr_addr,
  input  logic [UART_BYTE_W-1:0] wr_data,
  input  logic [DEPTH_LOG2-1:0]  rd_addr,
  output logic [UART_BYTE_W-1:0] rd_data
);

  logic [UART_BYTE_W-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue feeding the UART sender; a push into an empty idle queue is strobed 2 edges later.
// Pushes never stall: a push into a full queue with no pop is dropped and flagged in overflow.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                   CLK,
  input  logic                   RSTN,
  input  logic                   push,
  input  logic [UART_BYTE_W-1:0] push_data,
  output logic                   full,
  output logic [DEPTH_LOG2:0]    count,
  output logic                   overflow,
  output logic                   busy,
  output logic [UART_BYTE_W-1:0] tx_as,
  output logic                   tx_ready,
  input  logic                   tx_done
);

  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);

  tx_state_t               state;
  tx_state_t               state_nxt;
  logic [DEPTH_LOG2-1:0]   wr_ptr;
  logic [DEPTH_LOG2-1:0]   rd_ptr;
  logic [UART_BYTE_W-1:0]  head;
  logic                    pop;
  logic                    push_ok;

  // A pop frees a slot in the same cycle, so a full queue can still take a push then.
  assign pop     = (state == IDLE) && (count != '0);
  assign push_ok = push && (!full || pop);
  assign full    = (count == DEPTH_CNT);
  assign busy    = (count != '0) || ((state != IDLE) && (state != SYNC));

  tx_fifo_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk     (CLK),
    .we      (push_ok && RSTN),
    .wr_addr (wr_ptr),
    .wr_data (push_data),
    .rd_addr (rd_ptr),
    .rd_data (head)
  );

  // The sender has no reset, so after our reset we wait for it to report idle before launching.
  always_comb begin
    state_nxt = state;
    case (state)
      SYNC:      if (tx_done)  state_nxt = IDLE;
      IDLE:      if (pop)      state_nxt = LAUNCH;
      LAUNCH:                  state_nxt = WAIT_LOW;
      WAIT_LOW:  if (!tx_done) state_nxt = WAIT_HIGH;
      WAIT_HIGH: if (tx_done)  state_nxt = IDLE;
      default:                 state_nxt = SYNC;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state    <= SYNC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      tx_ready <= 1'b0;
      tx_as    <= '0;
    end else begin
      state    <= state_nxt;
      tx_ready <= (state_nxt == LAUNCH);
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        tx_as  <= head;
      end
      if (push && !push_ok) begin
        overflow <= 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue with a behavioural 1-cycle-per-bit sender and a done override.
module tb_uart_tx_queue;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       push = 1'b0;
  logic [7:0] push_data = 8'h00;
  logic       full, overflow, busy, tx_ready, tx_done;
  logic [4:0] count;
  logic [7:0] tx_as;

  logic       fen = 1'b0;
  logic       fval = 1'b0;

  int         nb = 0;
  logic [9:0] sh = '0;
  logic [7:0] launched[$];
  logic       bits_q[$];
  int         viol = 0;
  logic       prev_rdy = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rstn, push;
    logic [7:0] data;
    logic       fen, fval;
    logic [4:0] cnt;
    logic       full, ovf, busy, rdy;
    logic [7:0] as;
  } vec_t;

  vec_t vq[$];

  always #5 clk = ~clk;

  assign tx_done = fen ? fval : (nb == 0);

  uart_tx_queue #(.DEPTH_LOG2(4)) dut (
    .CLK       (clk),
    .RSTN      (rstn),
    .push      (push),
    .push_data (push_data),
    .full      (full),
    .count     (count),
    .overflow  (overflow),
    .busy      (busy),
    .tx_as     (tx_as),
    .tx_ready  (tx_ready),
    .tx_done   (tx_done)
  );

  // Sender: latches a frame on a strobe while idle, then shifts start, 8 data bits LSB first, stop.
  always @(posedge clk) begin
    if (nb == 0) begin
      if (tx_ready === 1'b1) begin
        sh <= {1'b1, tx_as, 1'b0};
        nb <= 10;
        launched.push_back(tx_as);
      end
    end else begin
      bits_q.push_back(sh[0]);
      sh <= sh >> 1;
      nb <= nb - 1;
    end
    if ((tx_ready === 1'b1) && (nb != 0 || prev_rdy === 1'b1)) viol <= viol + 1;
    prev_rdy <= tx_ready;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic p, input logic [7:0] d,
                              input logic fe, input logic fv, input logic [4:0] c,
                              input logic fu, input logic ov, input logic bu,
                              input logic rd, input logic [7:0] a);
    vec_t v;
    v.rstn = r;  v.push = p;  v.data = d;  v.fen = fe; v.fval = fv;
    v.cnt = c;   v.full = fu; v.ovf = ov;  v.busy = bu; v.rdy = rd; v.as = a;
    return v;
  endfunction

  task automatic run_vecs(input string tag);
    for (int i = 0; i < vq.size(); i++) begin
      rstn = vq[i].rstn; push = vq[i].push; push_data = vq[i].data;
      fen = vq[i].fen;   fval = vq[i].fval;
      @(posedge clk); #1;
      chk($sformatf("%s[%0d].count", tag, i),    32'(count),    32'(vq[i].cnt));
      chk($sformatf("%s[%0d].full", tag, i),     32'(full),     32'(vq[i].full));
      chk($sformatf("%s[%0d].overflow", tag, i), 32'(overflow), 32'(vq[i].ovf));
      chk($sformatf("%s[%0d].busy", tag, i),     32'(busy),     32'(vq[i].busy));
      chk($sformatf("%s[%0d].tx_ready", tag, i), 32'(tx_ready), 32'(vq[i].rdy));
      chk($sformatf("%s[%0d].tx_as", tag, i),    32'(tx_as),    32'(vq[i].as));
    end
    vq.delete();
    push = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_timeout"}, 32'(n < budget), 32'd1);
    chk({tag, "_line_idle_at_busy_fall"}, 32'(nb == 0), 32'd1);
  endtask

  initial begin
    logic [9:0] g;
    int         n;

    // Reset, single byte 0x41, launch latency and the start of its frame.
    vq.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00));
    vq.push_back(mk(0, 1, 8'h99, 0, 0, 0, 0, 0, 0, 0, 8'h00));
    vq.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00));
    vq.push_back(mk(1, 1, 8'h41, 0, 0, 1, 0, 0, 1, 0, 8'h00));
    vq.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 0, 1, 1, 8'h41));
    vq.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 8'h41));
    vq.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 8'h41));
    run_vecs("single");
    wait_idle("single", 100);
    chk("single_nbits", 32'(bits_q.size()), 32'd10);
    g = '0;
    for (int i = 0; i < bits_q.size() && i < 10; i++) g[i] = bits_q[i];
    chk("single_line_bits", 32'(g), 32'h282);
    chk("single_nlaunch", 32'(launched.size()), 32'd1);
    if (launched.size() > 0) chk("single_byte", 32'(launched[0]), 32'h41);

    // Fill to 16 with sender held off, then push into full on the pop cycle, then drain.
    launched.delete();
    vq.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 8'h00));
    for (int k = 1; k <= 16; k++)
      vq.push_back(mk(1, 1, 8'(k - 1), 1, 0, 5'(k), (k == 16), 0, 1, 0, 8'h00));
    vq.push_back(mk(1, 0, 8'h00, 0, 0, 16, 1, 0, 1, 0, 8'h00));
    vq.push_back(mk(1, 1, 8'h10, 0, 0, 16, 1, 0, 1, 1, 8'h00));
    run_vecs("fill");
    wait_idle("drain", 3000);
    chk("drain_nlaunch", 32'(launched.size()), 32'd17);
    for (int i = 0; i < launched.size() && i < 17; i++)
      chk($sformatf("drain_byte[%0d]", i), 32'(launched[i]), 32'(i));
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_full", 32'(full), 32'd0);

    // Overflow on the 17th push with no launches, sticky until reset; then slow accept.
    launched.delete();
    vq.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 8'h00));
    for (int k = 1; k <= 16; k++)
      vq.push_back(mk(1, 1, 8'(8'h80 + k), 1, 0, 5'(k), (k == 16), 0, 1, 0, 8'h00));
    vq.push_back(mk(1, 1, 8'hEE, 1, 0, 16, 1, 1, 1, 0, 8'h00));
    vq.push_back(mk(1, 0, 8'h00, 1, 0, 16, 1, 1, 1, 0, 8'h00));
    vq.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 8'h00));
    vq.push_back(mk(1, 0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 8'h00));
    vq.push_back(mk(1, 1, 8'h5A, 1, 1, 1, 0, 0, 1, 0, 8'h00));
    vq.push_back(mk(1, 0, 8'h00, 1, 1, 0, 0, 0, 1, 1, 8'h5A));
    vq.push_back(mk(1, 0, 8'h00, 1, 1, 0, 0, 0, 1, 0, 8'h5A));
    vq.push_back(mk(1, 0, 8'h00, 1, 1, 0, 0, 0, 1, 0, 8'h5A));
    vq.push_back(mk(1, 0, 8'h00, 1, 1, 0, 0, 0, 1, 0, 8'h5A));
    run_vecs("ovf_slow");
    fen = 1'b0;
    wait_idle("slow", 100);
    chk("slow_nlaunch", 32'(launched.size()), 32'd1);
    if (launched.size() > 0) chk("slow_byte", 32'(launched[0]), 32'h5A);

    // Reset mid-frame: the new byte must wait for the sender to go idle.
    launched.delete();
    push = 1'b1; push_data = 8'h33;
    @(posedge clk); #1;
    push = 1'b0;
    n = 0;
    while (nb == 0 && n < 10) begin @(posedge clk); #1; n++; end
    repeat (3) begin @(posedge clk); #1; end
    chk("mid_frame_active", 32'(nb != 0), 32'd1);
    rstn = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_ready", 32'(tx_ready), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    rstn = 1'b1; push = 1'b1; push_data = 8'h77;
    @(posedge clk); #1;
    push = 1'b0;
    chk("mid_count", 32'(count), 32'd1);
    n = 0;
    while (nb != 0 && n < 20) begin
      chk($sformatf("sync_hold[%0d]", n), 32'(tx_ready), 32'd0);
      @(posedge clk); #1;
      n++;
    end
    wait_idle("mid", 100);
    chk("mid_nlaunch", 32'(launched.size()), 32'd2);
    if (launched.size() > 1) begin
      chk("mid_byte0", 32'(launched[0]), 32'h33);
      chk("mid_byte1", 32'(launched[1]), 32'h77);
    end
    repeat (2) @(posedge clk);
    #1;
    chk("strobe_violations", 32'(viol), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
